load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_MSB, default 11, top bit of the memory word index; mem_addr[ADDR_MSB:2] is the word index.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  in  1  sign-extend sub-word loads.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  load result, or 0 for stores and errors.
REQ-013 rsp_err  out  1  misaligned or illegal-size request; qualified by rsp_valid.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  32  memory address, always word-aligned ({addr[31:2],2'b00}).
REQ-016 mem_wdata  out  32  memory write data.
REQ-017 mem_rdata  in  32  memory read data, registered by memory on the edge after mem_addr is presented.

Function
REQ-018 The unit SHALL implement FSM states IDLE, RD, WAIT, WR and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted at an edge where req_valid and req_ready are both 1.
REQ-020 On accept, all request fields SHALL be latched; later changes on the req_* inputs have no effect until the next accept.
REQ-021 Error condition: size 11, size 01 with addr[0]=1, or size 10 with addr[1:0]!=0.
REQ-022 On error: IDLE->RESP; rsp_err=1; rsp_rdata=0; mem_we never asserted.
REQ-023 Load: IDLE->RD->WAIT->RESP.
  - mem_addr is driven from RD onward.
  - In WAIT, the lane is extracted from mem_rdata and registered into rsp_rdata.
REQ-024 Lane selection is little-endian: byte k is at bits [8k+7:8k] with k=addr[1:0]; the halfword is at bits [16h+15:16h] with h=addr[1].
REQ-025 Sub-word load result SHALL be zero-extended when req_signed=0 and sign-extended when req_signed=1; req_signed is ignored for word loads.
REQ-026 Word store: IDLE->WR->RESP.
  - In WR: mem_we=1 and mem_wdata=req_wdata.
REQ-027 Sub-word store: IDLE->RD->WAIT->WR->RESP (read-modify-write).
  - In WAIT, mem_rdata is registered with only the addressed lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
  - WR writes the merged word.
REQ-028 mem_we SHALL be 1 only in WR, for exactly one cycle per store.
REQ-029 mem_addr and mem_wdata SHALL hold their last values outside RD/WAIT/WR.
REQ-030 RESP lasts exactly one cycle with rsp_valid=1 and then returns to IDLE; there is no response backpressure.
REQ-031 Latency, in cycles from accept edge to rsp_valid high: error 1, word store 2, load 3, sub-word store 4.
REQ-032 Throughput: a new request MAY be accepted at the edge that ends RESP? No; req_ready=0 in RESP, so at most one request is in flight.
REQ-033 rsp_err SHALL be 0 for legal requests; rsp_rdata SHALL be 0 in RESP for stores.

Reset
REQ-034 While rst_n=0, the unit SHALL hold, independent of clk:
  - state = IDLE; req_ready = 1.
  - rsp_valid, rsp_err, rsp_rdata = 0.
  - mem_we = 0; mem_addr and mem_wdata = 0.
REQ-035 Reset asserted mid-operation SHALL abort the transaction immediately, including deasserting mem_we during WR; no response is generated.
REQ-036 After rst_n rises, the first accept is possible at the first posedge.

Verification
REQ-037 Memory model preloaded word 4 = 0x8899AABB; load word at addr 0x10 -> rsp_valid in the 3rd cycle after accept, rsp_rdata=0x8899AABB, rsp_err=0.
REQ-038 Signed byte load at 0x13 -> rsp_rdata=0xFFFFFF88; unsigned halfword load at 0x12 -> 0x00008899.
REQ-039 Byte store 0x55 at 0x11 -> exactly one mem_we pulse, writing 0x889955BB to word 4; rsp_valid 4 cycles after accept.
REQ-040 Word load at 0x0E, and any request with size 11 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_rdata=0, mem_we stays 0.
REQ-041 Word store 0xDEADBEEF at 0x20 -> mem_we high in WR with mem_addr=0x20, rsp after 2 cycles; a subsequent load of 0x20 returns 0xDEADBEEF.
REQ-042 Assert rst_n=0 during the WR of a sub-word store -> mem_we falls immediately, no rsp_valid, req_ready=1.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the request/response handshake and the memory-side bus of the
//   load/store unit.
//   Request : req_valid, req_ready, req_we, req_size, req_signed, req_addr, req_wdata
//   Response: rsp_valid, rsp_rdata, rsp_err
//   Memory  : mem_we, mem_addr, mem_wdata, mem_rdata
//   slave  modport: the load/store unit itself.
//   master modport: the requester plus the memory, i.e. everything around the unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store unit in front of a word-wide memory with a
//   one-cycle registered read. Handles byte/halfword/word accesses, little-endian
//   lane selection, sign/zero extension, read-modify-write for sub-word stores
//   and alignment/size error detection.
//   Ports:
//     clk   - clock, all state on posedge
//     rst_n - asynchronous active-low reset
//     bus   - load_store_unit_if.slave (request, response and memory signals)
//   Parameter ADDR_MSB: top bit of the memory word index (mem_addr[ADDR_MSB:2]).
module load_store_unit #(
  parameter int ADDR_MSB = 11
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  // A word index needs at least bit 2 of the address; smaller values are meaningless.
  if (ADDR_MSB < 2) begin : g_addr_msb_too_small
  end

  // Size/alignment legality: 1 means the request must be rejected with rsp_err.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the old memory word with store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  state_t      state_r, state_nx;
  logic        accept_s, req_err_s;
  logic        we_r, sgn_r;
  logic [1:0]  size_r, off_r;
  logic [31:0] wdata_r;

  logic        req_ready_r, req_ready_nx;
  logic        rsp_valid_r, rsp_valid_nx;
  logic        rsp_err_r, rsp_err_nx;
  logic [31:0] rsp_rdata_r, rsp_rdata_nx;
  logic        mem_we_r, mem_we_nx;
  logic [31:0] mem_addr_r, mem_addr_nx;
  logic [31:0] mem_wdata_r, mem_wdata_nx;

  assign accept_s  = bus.req_valid && (state_r == IDLE);
  assign req_err_s = is_bad(bus.req_size, bus.req_addr[1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Next-state logic; word stores skip the read, sub-word stores read-modify-write.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                                   state_nx = IDLE;
        else if (req_err_s)                              state_nx = RESP;
        else if (bus.req_we && (bus.req_size == 2'b10))  state_nx = WR;
        else                                             state_nx = RD;
      end
      RD:      state_nx = WAIT;
      WAIT:    state_nx = we_r ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output next-values; everything is registered so outputs line up with the state.
  always_comb begin
    req_ready_nx = (state_nx == IDLE);
    rsp_valid_nx = (state_nx == RESP);
    mem_we_nx    = (state_nx == WR);
    rsp_err_nx   = rsp_err_r;
    rsp_rdata_nx = rsp_rdata_r;
    mem_addr_nx  = mem_addr_r;
    mem_wdata_nx = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          rsp_err_nx   = req_err_s;
          rsp_rdata_nx = 32'd0;
          if (!req_err_s) begin
            mem_addr_nx = {bus.req_addr[31:2], 2'b00};
            if (bus.req_we && (bus.req_size == 2'b10)) mem_wdata_nx = bus.req_wdata;
            else                                       mem_wdata_nx = mem_wdata_r;
          end else begin
            mem_addr_nx = mem_addr_r;
          end
        end else begin
          rsp_err_nx = rsp_err_r;
        end
      end
      WAIT: begin
        // mem_rdata is valid here: memory registered the address presented in RD.
        if (we_r) mem_wdata_nx = lane_merge(bus.mem_rdata, off_r, size_r, wdata_r);
        else      rsp_rdata_nx = lane_extract(bus.mem_rdata, off_r, size_r, sgn_r);
      end
      default: begin
        rsp_err_nx = rsp_err_r;
      end
    endcase
  end

  // Latch request fields at accept so later req_* changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      sgn_r   <= 1'b0;
      size_r  <= 2'b00;
      off_r   <= 2'b00;
      wdata_r <= 32'd0;
    end else if (accept_s) begin
      we_r    <= bus.req_we;
      sgn_r   <= bus.req_signed;
      size_r  <= bus.req_size;
      off_r   <= bus.req_addr[1:0];
      wdata_r <= bus.req_wdata;
    end
  end

  // Output registers; async reset also drops mem_we immediately during WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      req_ready_r <= req_ready_nx;
      rsp_valid_r <= rsp_valid_nx;
      rsp_err_r   <= rsp_err_nx;
      rsp_rdata_r <= rsp_rdata_nx;
      mem_we_r    <= mem_we_nx;
      mem_addr_r  <= mem_addr_nx;
      mem_wdata_r <= mem_wdata_nx;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed-vector scoreboard bench for load_store_unit. Stimulus pushes the
//   expected response (and any expected memory write) into queues; independent
//   monitors pop and compare whenever rsp_valid or mem_we is seen.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic mem_preload;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.ADDR_MSB(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Word memory with registered read, word 4 preloaded.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h8899AABB;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[11:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } rsp_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
  rsp_exp_t rsp_q[$];
  wr_exp_t  wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      rsp_exp_t e;
      if (rsp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Memory write monitor.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      wr_exp_t w;
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_write: got mem_we=1 addr 0x%08h expected no write", bus.mem_addr);
      end else begin
        w = wr_q.pop_front();
        check("mem_addr", bus.mem_addr, w.addr);
        check("mem_wdata", bus.mem_wdata, w.data);
      end
    end
  end

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_exp_t w;
    w.addr = addr;
    w.data = data;
    wr_q.push_back(w);
  endtask

  // Issue one request (called at a negedge) and wait for its response to be consumed.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n;
    rsp_exp_t e;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
      return;
    end
    bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
    rsp_q.push_back(e);
    // Scramble inputs to show the latched copy is what gets used.
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = ~size; bus.req_signed = ~sgn;
    bus.req_addr = ~addr; bus.req_wdata = ~wdata;
    n = 0;
    while (rsp_q.size() != 0 && n < 10) begin @(negedge clk); n++; end
    if (rsp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected response within 10 cycles");
      rsp_q.delete();
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; mem_preload = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    mem_preload = 1'b0;
    rst_n = 1'b1;

    // Loads of preloaded word 4 = 0x8899AABB.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008899, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h000000BB, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3);

    // Sub-word stores (read-modify-write).
    expect_write(32'h10, 32'h889955BB);
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hABCDEF55, 32'h0, 1'b0, 4);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h889955BB, 1'b0, 3);
    expect_write(32'h10, 32'h123455BB);
    issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 4);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h00000034, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0, 3);

    // Errors: no memory write expected.
    issue(1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h11111111, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b01, 1'b0, 32'h13, 32'h2222, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b10, 1'b0, 32'h22, 32'h33333333, 32'h0, 1'b1, 1);

    // Word store and readback.
    expect_write(32'h20, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h000000DE, 1'b0, 3);

    // Reset during WR of a byte store: write and response must be aborted.
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_we && n < 10) begin @(posedge clk); #1; n++; end
    check("abort_reached_wr", {31'd0, bus.mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("abort_rsp_valid_held", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    // Accept at the very first posedge after reset; word must be unchanged.
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    repeat (3) @(negedge clk);
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("write_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
